// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable N-bit serial pattern detector.
// Optional SEQDET_MASK_EN adds a per-bit don't-care mask loaded with the pattern.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   DEF_PAT = N'(4'b0110),
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pattern_in,
`ifdef SEQDET_MASK_EN
    input  logic [N-1:0]     mask_in,
`endif
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             filled
);

    localparam int            FW   = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    typedef enum logic {
        FILL = 1'b0,
        HUNT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [N-1:0]     pat_q, pat_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;

    logic [N-1:0]     h_next;
    logic [FW-1:0]    f_next;
    logic [N-1:0]     cur_mask;
    logic             hit;

`ifdef SEQDET_MASK_EN
    logic [N-1:0]     mask_q, mask_d;

    assign cur_mask = mask_q;

    // Mask register, loaded together with the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '1;
        else     mask_q <= mask_d;
    end

    // Mask follows load, otherwise holds.
    always_comb begin
        mask_d = mask_q;
        if (load) mask_d = mask_in;
    end
`else
    assign cur_mask = '1;
`endif

    // Candidate history, fill level and match for a qualified sample.
    always_comb begin
        h_next = {hist_q[N-2:0], x};
        f_next = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
        hit    = (f_next == FULL) &&
                 (((h_next ^ pat_q) & cur_mask) == '0);
    end

    // State registers; reset drops partial history and the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            hist_q  <= '0;
            pat_q   <= DEF_PAT;
            fill_q  <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

    // Next state: load beats sampling; a non-overlap match restarts the fill.
    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;
        if (load) begin
            pat_d  = pattern_in;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            hist_d = h_next;
            z_d    = hit;
            fill_d = (hit && !overlap) ? '0 : f_next;
            if (hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = (fill_d == FULL) ? HUNT : FILL;
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign filled    = (state_q == HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed checks against a queue-based model.
// Build with +define+SEQDET_MASK_EN to also exercise the don't-care mask.
module tb_seq_detector_param;

    localparam int           N       = 4;
    localparam logic [N-1:0] DEF_PAT = 4'b0110;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         x = 1'b0;
    logic         overlap = 1'b1;
    logic         load = 1'b0;
    logic [N-1:0] pattern_in = '0;
    logic [N-1:0] mask_tb = '1;
    logic         z, filled, z2, filled2;
    logic [7:0]   match_cnt;
    logic [1:0]   cnt2;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit           smp[$];
    logic [N-1:0] mpat;
    logic [N-1:0] mmask;
    int           mcnt8, mcnt2;
    bit           mz;

    always #5 clk = ~clk;

    seq_detector_param #(.N(N), .DEF_PAT(DEF_PAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .load(load), .pattern_in(pattern_in),
`ifdef SEQDET_MASK_EN
        .mask_in(mask_tb),
`endif
        .z(z), .match_cnt(match_cnt), .filled(filled)
    );

    seq_detector_param #(.N(N), .DEF_PAT(DEF_PAT), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .load(load), .pattern_in(pattern_in),
`ifdef SEQDET_MASK_EN
        .mask_in(mask_tb),
`endif
        .z(z2), .match_cnt(cnt2), .filled(filled2)
    );

    function automatic bit mfill();
        return smp.size() == N;
    endfunction

    task automatic mreset();
        smp.delete();
        mpat  = DEF_PAT;
        mmask = '1;
        mcnt8 = 0;
        mcnt2 = 0;
        mz    = 0;
    endtask

    // One clock edge of stimulus; model updated from the pattern rules.
    task automatic drive(input logic e, input logic xi, input logic ld,
                         input logic ov, input logic [N-1:0] pi);
        logic [N-1:0] w;
        @(negedge clk);
        en = e; x = xi; load = ld; overlap = ov; pattern_in = pi;
        @(posedge clk);
        mz = 0;
        if (ld) begin
            mpat = pi;
`ifdef SEQDET_MASK_EN
            mmask = mask_tb;
`endif
            smp.delete();
            mcnt8 = 0;
            mcnt2 = 0;
        end else if (e) begin
            smp.push_back(xi);
            if (smp.size() > N) void'(smp.pop_front());
            if (smp.size() == N) begin
                w = '0;
                foreach (smp[i]) w = {w[N-2:0], smp[i]};
                if (((w ^ mpat) & mmask) == '0) begin
                    mz = 1;
                    if (mcnt8 < 255) mcnt8++;
                    if (mcnt2 < 3) mcnt2++;
                    if (!ov) smp.delete();
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; load = 1'b0;
        mreset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({z, match_cnt, filled, z2, cnt2, filled2} !== 14'b0) begin
            fails++;
            $display("FAIL reset: z=%b cnt=%0d filled=%b cnt2=%0d, need all 0",
                     z, match_cnt, filled, cnt2);
        end
        do_reset();
    endtask

    task automatic run_stream(input string nm, input logic ov,
                              output logic [12:0] zs, output int fill5);
        logic [12:0] s = 13'b0011011011101;
        zs = '0;
        fill5 = -1;
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, s[12-i], 1'b0, ov, '0);
            zs[12-i] = z;
            if (i == 5) fill5 = int'(filled);
            tests++;
            if ({z, match_cnt, filled} !== {mz, 8'(mcnt8), mfill()}) begin
                fails++;
                $display("FAIL %s s%0d: z/cnt/filled=%b/%0d/%b need %b/%0d/%b",
                         nm, i + 1, z, match_cnt, filled, mz, mcnt8, mfill());
            end
        end
    endtask

    task automatic test_overlap();
        logic [12:0] zs;
        int f;
        do_reset();
        run_stream("ovl", 1'b1, zs, f);
        tests++;
        if (zs !== 13'b0000100100000 || match_cnt !== 8'd2) begin
            fails++;
            $display("FAIL ovl_sum: z=%b cnt=%0d need 0000100100000 cnt 2",
                     zs, match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [12:0] zs;
        int f;
        do_reset();
        run_stream("novl", 1'b0, zs, f);
        tests++;
        if (zs !== 13'b0000100000000 || match_cnt !== 8'd1 || f != 0) begin
            fails++;
            $display("FAIL novl_sum: z=%b cnt=%0d filled6=%0d need 0000100000000 1 0",
                     zs, match_cnt, f);
        end
    endtask

    task automatic test_en_gaps();
        logic [12:0] s = 13'b0011011011101;
        logic [12:0] zs = '0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 1'($urandom), 1'b0, 1'b1, '0);
                    tests++;
                    if (z !== 1'b0 || match_cnt !== 8'(mcnt8)) begin
                        fails++;
                        $display("FAIL gap%0d: z=%b cnt=%0d need 0 %0d",
                                 g, z, match_cnt, mcnt8);
                    end
                end
            end
            drive(1'b1, s[12-i], 1'b0, 1'b1, '0);
            zs[12-i] = z;
            tests++;
            if ({z, match_cnt, filled} !== {mz, 8'(mcnt8), mfill()}) begin
                fails++;
                $display("FAIL en s%0d: z/cnt/filled=%b/%0d/%b need %b/%0d/%b",
                         i + 1, z, match_cnt, filled, mz, mcnt8, mfill());
            end
        end
        tests++;
        if (zs !== 13'b0000100100000 || match_cnt !== 8'd2) begin
            fails++;
            $display("FAIL en_sum: z=%b cnt=%0d need 0000100100000 2", zs, match_cnt);
        end
    endtask

    task automatic test_load();
        logic [4:0] pre = 5'b00110;
        logic [4:0] zs = '0;
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, pre[4-i], 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
        tests++;
        if (match_cnt !== 8'd0 || filled !== 1'b0 || z !== 1'b0) begin
            fails++;
            $display("FAIL load_clr: cnt=%0d filled=%b z=%b need 0 0 0",
                     match_cnt, filled, z);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
            zs[4-i] = z;
            tests++;
            if ({z, match_cnt} !== {mz, 8'(mcnt8)}) begin
                fails++;
                $display("FAIL load s%0d: z=%b cnt=%0d need %b %0d",
                         i + 1, z, match_cnt, mz, mcnt8);
            end
        end
        tests++;
        if (zs !== 5'b00011 || match_cnt !== 8'd2) begin
            fails++;
            $display("FAIL load_sum: z=%b cnt=%0d need 00011 2", zs, match_cnt);
        end
    endtask

    task automatic test_saturate();
        int hits = 0;
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
            if (z2) hits++;
            tests++;
            if ({z2, cnt2} !== {mz, 2'(mcnt2)}) begin
                fails++;
                $display("FAIL sat s%0d: z=%b cnt=%0d need %b %0d",
                         i + 1, z2, cnt2, mz, mcnt2);
            end
        end
        tests++;
        if (hits != 7 || cnt2 !== 2'd3) begin
            fails++;
            $display("FAIL sat_sum: hits=%0d cnt=%0d need 7 3", hits, cnt2);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] s = 4'b0110;
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, '0);
        tests++;
        if ({z, match_cnt} !== {mz, 8'(mcnt8)}) begin
            fails++;
            $display("FAIL pre_rst: z=%b cnt=%0d need %b %0d", z, match_cnt, mz, mcnt8);
        end
        #2 rst = 1'b1;
        #1;
        mreset();
        tests++;
        if ({z, match_cnt, filled, cnt2} !== 11'b0) begin
            fails++;
            $display("FAIL async_rst: z=%b cnt=%0d filled=%b need 0 0 0",
                     z, match_cnt, filled);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, s[3-i], 1'b0, 1'b1, '0);
            tests++;
            if (z !== (i == 3) || z !== mz) begin
                fails++;
                $display("FAIL post_rst s%0d: z=%b need %b", i + 1, z, mz);
            end
        end
    endtask

    task automatic test_random();
        logic e, xi, ld, ov;
        logic [N-1:0] pi;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            xi = 1'($urandom);
            ld = ($urandom_range(0, 39) == 0);
            ov = ($urandom_range(0, 3) != 0);
            pi = N'($urandom);
            drive(e, xi, ld, ov, pi);
            tests++;
            if ({z, match_cnt, filled, z2, cnt2, filled2} !==
                {mz, 8'(mcnt8), mfill(), mz, 2'(mcnt2), mfill()}) begin
                fails++;
                $display("FAIL rand c%0d: z=%b cnt=%0d f=%b cnt2=%0d need %b %0d %b %0d",
                         i, z, match_cnt, filled, cnt2, mz, mcnt8, mfill(), mcnt2);
            end
        end
    endtask

`ifdef SEQDET_MASK_EN
    task automatic test_mask();
        do_reset();
        mask_tb = 4'b1001;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, '0);
            tests++;
            if (z !== (i == 3) || z !== mz) begin
                fails++;
                $display("FAIL mask s%0d: z=%b need %b", i + 1, z, mz);
            end
        end
        mask_tb = '1;
    endtask
`endif

    initial begin
        mreset();
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_en_gaps();
        test_load();
        test_saturate();
        test_async_reset();
        test_random();
`ifdef SEQDET_MASK_EN
        test_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
